// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N:1 stream multiplexer.
// Holds the channel-index width function and the mode encodings.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int cw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_1_slice.sv
// One SLICE_W-bit lane of the N:1 data selector.
// An out-of-range index selects all zeros.
module mux_n_1_slice
  import stream_mux_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int SLICE_W = 2,
  localparam int CW      = cw_of(N)
) (
  input  logic [N*SLICE_W-1:0] i_data,
  input  logic [CW-1:0]        i_sel,
  output logic [SLICE_W-1:0]   o_data
);

  // pick the lane of the indexed channel
  always_comb begin
    o_data = '0;
    for (int i = 0; i < N; i++) begin
      if (i_sel == CW'(i)) begin
        o_data = i_data[i*SLICE_W +: SLICE_W];
      end
    end
  end

endmodule

// File: rtl/stream_mux_n_1.sv
// N:1 valid/ready stream mux with fixed or round-robin
// arbitration feeding a single-entry output register.
module stream_mux_n_1
  import stream_mux_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int W       = 8,
  parameter  int SLICE_W = 2,
  localparam int CW      = cw_of(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rr_mode,
  input  logic [CW-1:0]  sel,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [CW-1:0]  out_ch
);

  localparam int NS = W / SLICE_W;
  localparam int PW = 1 << CW;
  localparam logic [CW:0] N_EXT = (CW+1)'(N);

  if ((W % SLICE_W) != 0) begin : g_bad_slice
    $error("W must be a multiple of SLICE_W");
  end
  if (N < 2 || N > 16) begin : g_bad_n
    $error("N must be in 2..16");
  end

  logic [CW-1:0] r_rr_ptr;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [CW-1:0] r_out_ch;

  logic [CW-1:0] w_rr_grant;
  logic          w_rr_valid;
  logic          w_fix_valid;
  logic [CW-1:0] w_grant;
  logic          w_grant_valid;
  logic          w_accept;
  logic          w_load;
  logic [PW-1:0] w_vld_pad;
  logic [CW:0]   w_sel_ext;
  logic [W-1:0]  w_mux_data;

  assign w_vld_pad   = PW'(in_valid);
  assign w_sel_ext   = {1'b0, sel};
  assign w_fix_valid = (w_sel_ext < N_EXT) && w_vld_pad[sel];

  // round-robin search: walk far-to-near so the nearest
  // requester after rr_ptr is the one left standing
  always_comb begin
    int c;
    c          = 0;
    w_rr_grant = '0;
    for (int k = N; k >= 1; k--) begin
      c = int'(r_rr_ptr) + k;
      if (c >= N) c = c - N;
      if (in_valid[c]) w_rr_grant = CW'(c);
    end
    w_rr_valid = |in_valid;
  end

  assign w_grant       = (rr_mode == MODE_RR) ? w_rr_grant : sel;
  assign w_grant_valid = (rr_mode == MODE_RR) ? w_rr_valid
                                              : w_fix_valid;

  // reset gates the load so in_ready stays low in reset
  assign w_accept = !r_out_valid || out_ready;
  assign w_load   = rst_n && w_accept && w_grant_valid;
  assign in_ready = w_load ? (N'(1) << w_grant) : '0;

  for (genvar s = 0; s < NS; s++) begin : g_slice
    logic [N*SLICE_W-1:0] w_sl;
    for (genvar i = 0; i < N; i++) begin : g_ch
      assign w_sl[i*SLICE_W +: SLICE_W] =
        in_data[i*W + s*SLICE_W +: SLICE_W];
    end
    mux_n_1_slice #(
      .N       (N),
      .SLICE_W (SLICE_W)
    ) u_mux (
      .i_data (w_sl),
      .i_sel  (w_grant),
      .o_data (w_mux_data[s*SLICE_W +: SLICE_W])
    );
  end

  // output register slice: load, drain, or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_ch    <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // round-robin pointer advances only on a round-robin load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= CW'(N-1);
    end else if (w_load && rr_mode == MODE_RR) begin
      r_rr_ptr <= w_grant;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_n_1.sv
// Randomized bench for stream_mux_n_1 at three slice widths
// against a transaction-level reference model.
module tb_stream_mux_n_1;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;
  localparam int ND = 3;

  logic           clk;
  logic           rst_n;
  logic           rr_mode;
  logic [CW-1:0]  sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic           out_ready;
  logic [W-1:0]   d [N];

  logic [N-1:0]  rdy_a, rdy_b, rdy_c;
  logic          ov_a, ov_b, ov_c;
  logic [W-1:0]  od_a, od_b, od_c;
  logic [CW-1:0] oc_a, oc_b, oc_c;

  logic [N-1:0]  rdy [ND];
  logic          ov  [ND];
  logic [W-1:0]  od  [ND];
  logic [CW-1:0] oc  [ND];

  int n_err = 0;
  int n_chk = 0;

  bit       m_vld;
  int       m_data;
  int       m_ch;
  int       m_ptr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) in_data[i*W +: W] = d[i];
  end

  assign rdy[0] = rdy_a; assign rdy[1] = rdy_b; assign rdy[2] = rdy_c;
  assign ov[0]  = ov_a;  assign ov[1]  = ov_b;  assign ov[2]  = ov_c;
  assign od[0]  = od_a;  assign od[1]  = od_b;  assign od[2]  = od_c;
  assign oc[0]  = oc_a;  assign oc[1]  = oc_b;  assign oc[2]  = oc_c;

  stream_mux_n_1 #(.N(N), .W(W), .SLICE_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_a),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
    .out_ch(oc_a)
  );

  stream_mux_n_1 #(.N(N), .W(W), .SLICE_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_b),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
    .out_ch(oc_b)
  );

  stream_mux_n_1 #(.N(N), .W(W), .SLICE_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_c),
    .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c),
    .out_ch(oc_c)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string t);
    for (int j = 0; j < ND; j++) begin
      check($sformatf("%s.valid%0d", t, j), 32'(ov[j]), 32'(m_vld));
      check($sformatf("%s.data%0d", t, j), 32'(od[j]), m_data);
      check($sformatf("%s.ch%0d", t, j), 32'(oc[j]), m_ch);
    end
  endtask

  task automatic check_rdy(input string t, input int exp);
    for (int j = 0; j < ND; j++)
      check($sformatf("%s.rdy%0d", t, j), 32'(rdy[j]), exp);
  endtask

  // one clock of the reference: arbitrate, then update the slot
  task automatic cycle(input string t);
    int  g;
    bit  gv;
    bit  ld;
    int  er;
    g  = 0;
    gv = 0;
    #1;
    if (!rr_mode) begin
      g  = int'(sel);
      gv = (g < N) && in_valid[g];
    end else begin
      for (int k = 1; k <= N && !gv; k++) begin
        if (in_valid[(m_ptr + k) % N]) begin
          g  = (m_ptr + k) % N;
          gv = 1;
        end
      end
    end
    ld = (!m_vld || out_ready) && gv;
    er = ld ? (1 << g) : 0;
    check_rdy(t, er);
    @(posedge clk);
    if (ld) begin
      m_vld  = 1;
      m_data = int'(d[g]);
      m_ch   = g;
      if (rr_mode) m_ptr = g;
    end else if (out_ready) begin
      m_vld = 0;
    end
    #1;
    check_outs(t);
  endtask

  task automatic apply_reset(input string t);
    rst_n = 1'b0;
    #1;
    m_vld  = 0;
    m_data = 0;
    m_ch   = 0;
    m_ptr  = N - 1;
    check_outs(t);
    check_rdy(t, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_seq [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst_n     = 1'b0;
    rr_mode   = 1'b0;
    sel       = '0;
    in_valid  = '1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) d[i] = W'(8'h10 + i);
    apply_reset("reset");

    // fixed mode, channel 2 only
    rr_mode  = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b0100;
    d[2]     = 8'hA5;
    cycle("fix_sel2");
    check("fix_data", 32'(od_a), 32'hA5);
    check("fix_ch", 32'(oc_a), 32'd2);

    // round-robin from reset, all requesting
    in_valid = '0;
    apply_reset("reset2");
    rr_mode  = 1'b1;
    in_valid = '1;
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < N; c++) d[c] = W'($urandom);
      cycle("rr_run");
      check("rr_seq", 32'(oc_a), exp_seq[i]);
      check("rr_vld", 32'(ov_a), 32'd1);
    end

    // backpressure for three cycles
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < N; c++) d[c] = W'($urandom);
      cycle("bp_hold");
    end
    out_ready = 1'b1;
    cycle("bp_release");
    check("bp_next", 32'(oc_a), 32'd2);

    // drain, then fixed select on an idle channel
    rr_mode  = 1'b0;
    in_valid = '0;
    cycle("drain");
    sel      = 2'd1;
    in_valid = 4'b1101;
    cycle("fix_idle");
    cycle("fix_idle2");
    check("idle_vld", 32'(ov_a), 32'd0);

    // reset while holding an unaccepted item
    rr_mode   = 1'b1;
    in_valid  = '1;
    cycle("pre_rst");
    out_ready = 1'b0;
    cycle("pre_rst_hold");
    check("held_vld", 32'(ov_a), 32'd1);
    #2;
    apply_reset("mid_rst");
    out_ready = 1'b1;
    cycle("post_rst");
    check("post_rst_ch", 32'(oc_a), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) rr_mode = ~rr_mode;
      sel       = CW'($urandom_range(0, N-1));
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int c = 0; c < N; c++) d[c] = W'($urandom);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_mux_n_1.md
STREAM_MUX_N_1 -- requirements
Module: stream_mux_n_1

Interface
REQ-001 SHALL have parameter N, default 4, meaning the number of input channels (legal range 2..16).
REQ-002 SHALL have parameter W, default 8, meaning the data width per channel.
REQ-003 SHALL have parameter SLICE_W, default 2, meaning the data slice width; W SHALL be a multiple of SLICE_W, checked at elaboration.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rr_mode, input, 1 bit: 0 = fixed select, 1 = round-robin arbitration.
REQ-007 SHALL have port sel, input, CW = $clog2(N) bits: the channel chosen in fixed mode.
REQ-008 SHALL have port in_valid, input, N bits: per-channel valid.
REQ-009 SHALL have port in_data, input, N*W bits: channel i occupies bits [i*W +: W].
REQ-010 SHALL have port in_ready, output, N bits: per-channel ready.
REQ-011 SHALL have port out_valid, output, 1 bit: the output register holds data.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream accepts.
REQ-013 SHALL have port out_data, output, W bits: the registered data of the selected channel.
REQ-014 SHALL have port out_ch, output, CW bits: the channel index of the data in out_data.

Function
REQ-015 SHALL define load = (!out_valid || out_ready) && grant_valid; the output is a single-entry register slice.
REQ-016 SHALL, in fixed mode: grant = sel, grant_valid = in_valid[sel] && (sel < N); sel >= N grants nothing.
REQ-017 SHALL, in round-robin mode: grant = first channel with in_valid set, searching cyclically from rr_ptr+1 (wrap N-1 -> 0); grant_valid = |in_valid.
REQ-018 SHALL set in_ready[i] = 1 only when i == grant, grant_valid = 1 and (!out_valid || out_ready); all other bits 0; in_ready is combinational.
REQ-019 SHALL, on a load: out_data <= in_data of grant, out_ch <= grant, out_valid <= 1; latency in_valid -> out_valid is 1 cycle.
REQ-020 SHALL, on a load in round-robin mode, update rr_ptr <= grant; rr_ptr SHALL NOT change in fixed mode or without a load.
REQ-021 SHALL, when out_valid && out_ready && !load, clear out_valid to 0 and hold out_data/out_ch.
REQ-022 SHALL hold out_valid, out_data and out_ch stable while out_valid && !out_ready (backpressure).
REQ-023 SHALL sustain one transfer per cycle when out_ready is held at 1 (simultaneous drain and load in the same cycle).
REQ-024 SHALL sample rr_mode and sel every cycle; a change affects only the next grant and never the held output.
REQ-025 SHALL build the data selection from W/SLICE_W instances of the slice mux, all sharing one grant index.

Reset
REQ-026 SHALL, while rst_n = 0: out_valid = 0, out_data = 0, out_ch = 0, rr_ptr = N-1 (channel 0 first in round-robin), in_ready = 0.
REQ-027 SHALL discard a held, unaccepted output on reset mid-transfer; the first load after rst_n rises SHALL occur no earlier than the next edge.

Structure
REQ-028 SHALL place the CW width function and mode encodings (MODE_FIXED = 0, MODE_RR = 1) in package stream_mux_pkg.
REQ-029 SHALL use one combinational sub-module, mux_n_1_slice (parameters N, SLICE_W), that selects one SLICE_W slice of N inputs by index.
REQ-030 SHALL keep the arbiter (grant, rr_ptr) in the top module; no other sub-modules.

Verification
REQ-031 Fixed mode, N=4, W=8: sel=2, in_valid=4'b0100, data2=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=A5, out_ch=2, in_ready=4'b0100 in the load cycle.
REQ-032 Round-robin, all in_valid=1, out_ready=1 for 6 cycles after reset -> out_ch sequence 0,1,2,3,0,1, one item per cycle.
REQ-033 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_ch unchanged, in_ready=0; out_ready=1 -> new item the next cycle.
REQ-034 Fixed mode, sel=1, in_valid=4'b1101 -> no load, in_ready=0, out_valid stays 0.
REQ-035 rst_n asserted low mid-stream while out_valid=1 -> out_valid=0 immediately (asynchronous); after release round-robin restarts at channel 0.
REQ-036 W=8, SLICE_W=4 vs SLICE_W=1 with random traffic -> identical out_data/out_ch streams compared against a reference model.
